// File: rtl/kf8255_handshake_control_pkg.sv
// Shared definitions for the 8255 handshake control: mode encodings, INTE select and effective mode.
package kf8255_handshake_control_pkg;

  localparam logic [1:0] CONTROL_MODE_0 = 2'b00;
  localparam logic [1:0] CONTROL_MODE_1 = 2'b01;
  localparam logic [1:0] CONTROL_MODE_2 = 2'b10;

  localparam logic PORT_INPUT  = 1'b1;
  localparam logic PORT_OUTPUT = 1'b0;

  localparam logic INTE_SEL_IN  = 1'b0;
  localparam logic INTE_SEL_OUT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IN1   = 2'd1,
    OUT1  = 2'd2,
    BIDIR = 2'd3
  } eff_mode_t;

  // Collapse control-word mode and direction into the handshake behaviour in force.
  function automatic eff_mode_t eff_mode(input logic [1:0] mode_sel, input logic port_io,
                                         input logic mode2_en);
    eff_mode_t m;
    m = IDLE;
    case (mode_sel)
      CONTROL_MODE_0: m = IDLE;
      CONTROL_MODE_1: m = (port_io == PORT_OUTPUT) ? OUT1 : IN1;
      CONTROL_MODE_2: m = mode2_en ? BIDIR : IDLE;
      default:        m = IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/kf8255_pin_sync.sv
// Multi-stage synchroniser for an active-low handshake pin with falling-edge detect.
// A fall is only reported when the previous synchronised value was a real pin sample,
// so a pin held low across reset does not look like a fresh edge.
module kf8255_pin_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pin_n,
  output logic level_s,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic [STAGES-1:0] vld_q, vld_d;
  logic              prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;

  // Shift the pin and a sample-valid marker through the chain.
  always_comb begin
    sync_d     = {sync_q[STAGES-2:0], pin_n};
    vld_d      = {vld_q[STAGES-2:0], 1'b1};
    prev_d     = sync_q[STAGES-1];
    prev_vld_d = vld_q[STAGES-1];
  end

  // Chain registers; idle level is high.
  always_ff @(negedge clock) begin
    if (reset) begin
      sync_q     <= '1;
      vld_q      <= '0;
      prev_q     <= 1'b1;
      prev_vld_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      vld_q      <= vld_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  assign level_s = sync_q[STAGES-1];
  assign fall_c  = prev_vld_q & prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/kf8255_handshake_control.sv
// Mode 1 / Mode 2 handshake sequencer for one 8255 port group: strobe/hiz to the port,
// IBF/OBF_n/INTE/INTR status flags for read-back and interrupt pins.
module kf8255_handshake_control
  import kf8255_handshake_control_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          MODE2_EN    = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] mode_select_reg,
  input  logic       port_io_reg,
  input  logic       update_mode,
  input  logic       read_port,
  input  logic       write_port,
  input  logic       write_inte,
  input  logic       inte_sel,
  input  logic       inte_value,
  input  logic       stb_n,
  input  logic       ack_n,
  output logic       strobe,
  output logic       hiz,
  output logic       ibf,
  output logic       obf_n,
  output logic       intr,
  output logic       inte_in,
  output logic       inte_out
);

  eff_mode_t mode;
  logic      stb_s, stb_fall, ack_s, ack_fall;
  logic      use_in, use_out;
  logic      rd_start, rd_end, rd_busy, wr_start, wr_end, wr_busy;

  logic rd_q, rd_d, wr_q, wr_d;
  logic ibf_q, ibf_d, obf_n_q, obf_n_d;
  logic in_req_q, in_req_d, out_req_q, out_req_d;
  logic inte_in_q, inte_in_d, inte_out_q, inte_out_d;

  kf8255_pin_sync #(.STAGES(SYNC_STAGES)) u_stb_sync (
    .clock   (clock),
    .reset   (reset),
    .pin_n   (stb_n),
    .level_s (stb_s),
    .fall_c  (stb_fall)
  );

  kf8255_pin_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clock   (clock),
    .reset   (reset),
    .pin_n   (ack_n),
    .level_s (ack_s),
    .fall_c  (ack_fall)
  );

  assign mode    = eff_mode(mode_select_reg, port_io_reg, MODE2_EN);
  assign use_in  = (mode == IN1) || (mode == BIDIR);
  assign use_out = (mode == OUT1) || (mode == BIDIR);

  // Next-state for access history, buffer flags, interrupt terms and INTE bits.
  always_comb begin
    rd_d       = read_port;
    wr_d       = write_port;
    rd_start   = read_port & ~rd_q;
    rd_end     = ~read_port & rd_q;
    wr_start   = write_port & ~wr_q;
    wr_end     = ~write_port & wr_q;
    rd_busy    = read_port | rd_q;
    wr_busy    = write_port | wr_q;
    ibf_d      = ibf_q;
    obf_n_d    = obf_n_q;
    in_req_d   = in_req_q;
    out_req_d  = out_req_q;
    inte_in_d  = inte_in_q;
    inte_out_d = inte_out_q;

    if (write_inte) begin
      if (inte_sel == INTE_SEL_OUT) inte_out_d = inte_value;
      else                          inte_in_d  = inte_value;
    end

    // New strobed data beats a finishing read.
    if (stb_fall)    ibf_d = 1'b1;
    else if (rd_end) ibf_d = 1'b0;

    // Freshly written data beats an acknowledge of the old data.
    if (wr_end)        obf_n_d = 1'b0;
    else if (ack_fall) obf_n_d = 1'b1;

    // Requests are not re-raised by the very access that is servicing them.
    if (rd_start || !inte_in_d)                           in_req_d = 1'b0;
    else if (stb_s && ibf_q && !rd_busy)                  in_req_d = 1'b1;

    if (wr_start || !inte_out_d)                          out_req_d = 1'b0;
    else if (ack_s && obf_n_q && !wr_busy)                out_req_d = 1'b1;

    if (!use_in) begin
      ibf_d    = 1'b0;
      in_req_d = 1'b0;
    end
    if (!use_out) begin
      obf_n_d   = 1'b1;
      out_req_d = 1'b0;
    end

    if (update_mode) begin
      ibf_d      = 1'b0;
      obf_n_d    = 1'b1;
      in_req_d   = 1'b0;
      out_req_d  = 1'b0;
      inte_in_d  = 1'b0;
      inte_out_d = 1'b0;
    end
  end

  // State registers, updated on the falling edge with the port datapath.
  always_ff @(negedge clock) begin
    if (reset) begin
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ibf_q      <= 1'b0;
      obf_n_q    <= 1'b1;
      in_req_q   <= 1'b0;
      out_req_q  <= 1'b0;
      inte_in_q  <= 1'b0;
      inte_out_q <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      ibf_q      <= ibf_d;
      obf_n_q    <= obf_n_d;
      in_req_q   <= in_req_d;
      out_req_q  <= out_req_d;
      inte_in_q  <= inte_in_d;
      inte_out_q <= inte_out_d;
    end
  end

  // Port controls and interrupt selection by effective mode.
  always_comb begin
    strobe = 1'b0;
    hiz    = 1'b1;
    intr   = 1'b0;
    if (use_in)         strobe = ~stb_s;
    if (mode == BIDIR)  hiz    = ack_s;
    case (mode)
      IN1:     intr = in_req_q;
      OUT1:    intr = out_req_q;
      BIDIR:   intr = in_req_q | out_req_q;
      default: intr = 1'b0;
    endcase
  end

  assign ibf      = ibf_q;
  assign obf_n    = obf_n_q;
  assign inte_in  = inte_in_q;
  assign inte_out = inte_out_q;

endmodule

// File: tb/tb_kf8255_handshake_control.sv
// Directed bench for kf8255_handshake_control; a second instance has Mode 2 disabled.
module tb_kf8255_handshake_control;
  import kf8255_handshake_control_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] mode_select_reg;
  logic       port_io_reg, update_mode, read_port, write_port;
  logic       write_inte, inte_sel, inte_value, stb_n, ack_n;
  logic       strobe, hiz, ibf, obf_n, intr, inte_in, inte_out;
  logic       b_strobe, b_hiz, b_ibf, b_obf_n, b_intr, b_inte_in, b_inte_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  kf8255_handshake_control #(.SYNC_STAGES(2), .MODE2_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .mode_select_reg(mode_select_reg), .port_io_reg(port_io_reg),
    .update_mode(update_mode), .read_port(read_port), .write_port(write_port),
    .write_inte(write_inte), .inte_sel(inte_sel), .inte_value(inte_value),
    .stb_n(stb_n), .ack_n(ack_n), .strobe(strobe), .hiz(hiz), .ibf(ibf), .obf_n(obf_n),
    .intr(intr), .inte_in(inte_in), .inte_out(inte_out)
  );

  kf8255_handshake_control #(.SYNC_STAGES(2), .MODE2_EN(1'b0)) dut_b (
    .clock(clock), .reset(reset), .mode_select_reg(mode_select_reg), .port_io_reg(port_io_reg),
    .update_mode(update_mode), .read_port(read_port), .write_port(write_port),
    .write_inte(write_inte), .inte_sel(inte_sel), .inte_value(inte_value),
    .stb_n(stb_n), .ack_n(ack_n), .strobe(b_strobe), .hiz(b_hiz), .ibf(b_ibf), .obf_n(b_obf_n),
    .intr(b_intr), .inte_in(b_inte_in), .inte_out(b_inte_out)
  );

  // DUT updates on the falling edge; inputs are driven and outputs sampled just after the rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m, input logic io);
    mode_select_reg = m;
    port_io_reg     = io;
    update_mode     = 1'b1;
    cyc(1);
    update_mode     = 1'b0;
  endtask

  task automatic set_inte(input logic sel, input logic val);
    write_inte = 1'b1;
    inte_sel   = sel;
    inte_value = val;
    cyc(1);
    write_inte = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    n_checks++;
    if ({strobe, hiz, ibf, obf_n, intr, inte_in, inte_out} !== 7'b0101000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0101000",
               {strobe, hiz, ibf, obf_n, intr, inte_in, inte_out});
    end
    n_checks++;
    if ({b_strobe, b_hiz, b_ibf, b_obf_n, b_intr, b_inte_in, b_inte_out} !== 7'b0101000) begin
      n_fail++;
      $display("FAIL reset_outputs_b: got %b expected 0101000",
               {b_strobe, b_hiz, b_ibf, b_obf_n, b_intr, b_inte_in, b_inte_out});
    end
  endtask

  task automatic test_mode1_input();
    set_mode(CONTROL_MODE_1, PORT_INPUT);
    set_inte(INTE_SEL_IN, 1'b1);
    n_checks++;
    if (inte_in !== 1'b1) begin n_fail++; $display("FAIL in1_inte_in: got %b expected 1", inte_in); end
    stb_n = 1'b0;                                   // cycle 0
    cyc(1);
    n_checks++;
    if (strobe !== 1'b0) begin n_fail++; $display("FAIL in1_strobe_c1: got %b expected 0", strobe); end
    cyc(1);                                         // cycle 2
    n_checks++;
    if ({strobe, ibf} !== 2'b10) begin n_fail++; $display("FAIL in1_c2 strobe,ibf: got %b expected 10", {strobe, ibf}); end
    cyc(1);                                         // cycle 3
    n_checks++;
    if ({strobe, ibf} !== 2'b11) begin n_fail++; $display("FAIL in1_c3 strobe,ibf: got %b expected 11", {strobe, ibf}); end
    stb_n = 1'b1;
    cyc(1);                                         // cycle 4
    n_checks++;
    if ({strobe, intr} !== 2'b10) begin n_fail++; $display("FAIL in1_c4 strobe,intr: got %b expected 10", {strobe, intr}); end
    cyc(1);                                         // cycle 5: stb_s high again
    n_checks++;
    if ({strobe, intr} !== 2'b00) begin n_fail++; $display("FAIL in1_c5 strobe,intr: got %b expected 00", {strobe, intr}); end
    cyc(1);                                         // cycle 6
    n_checks++;
    if ({ibf, intr} !== 2'b11) begin n_fail++; $display("FAIL in1_c6 ibf,intr: got %b expected 11", {ibf, intr}); end
    read_port = 1'b1;
    cyc(1);
    n_checks++;
    if ({ibf, intr} !== 2'b10) begin n_fail++; $display("FAIL in1_rd_rise ibf,intr: got %b expected 10", {ibf, intr}); end
    read_port = 1'b0;
    cyc(1);
    n_checks++;
    if ({ibf, intr} !== 2'b00) begin n_fail++; $display("FAIL in1_rd_fall ibf,intr: got %b expected 00", {ibf, intr}); end
    cyc(2);
    n_checks++;
    if (intr !== 1'b0) begin n_fail++; $display("FAIL in1_intr_stays_low: got %b expected 0", intr); end
  endtask

  task automatic test_mode1_output();
    set_mode(CONTROL_MODE_1, PORT_OUTPUT);
    n_checks++;
    if ({obf_n, intr, inte_out} !== 3'b100) begin n_fail++; $display("FAIL out1_mode_set obf_n,intr,inte_out: got %b expected 100", {obf_n, intr, inte_out}); end
    set_inte(INTE_SEL_OUT, 1'b1);
    cyc(1);
    n_checks++;
    if (intr !== 1'b1) begin n_fail++; $display("FAIL out1_idle_req: got %b expected 1", intr); end
    write_port = 1'b1;
    cyc(1);
    n_checks++;
    if ({obf_n, intr} !== 2'b10) begin n_fail++; $display("FAIL out1_wr_rise obf_n,intr: got %b expected 10", {obf_n, intr}); end
    cyc(1);
    write_port = 1'b0;
    cyc(1);
    n_checks++;
    if ({obf_n, intr} !== 2'b00) begin n_fail++; $display("FAIL out1_wr_fall obf_n,intr: got %b expected 00", {obf_n, intr}); end
    cyc(2);
    ack_n = 1'b0;                                   // A
    cyc(2);
    n_checks++;
    if ({obf_n, hiz} !== 2'b01) begin n_fail++; $display("FAIL out1_ack_a2 obf_n,hiz: got %b expected 01", {obf_n, hiz}); end
    cyc(1);                                         // A+3
    n_checks++;
    if ({obf_n, intr} !== 2'b10) begin n_fail++; $display("FAIL out1_ack_a3 obf_n,intr: got %b expected 10", {obf_n, intr}); end
    ack_n = 1'b1;                                   // B
    cyc(2);
    n_checks++;
    if (intr !== 1'b0) begin n_fail++; $display("FAIL out1_ack_b2 intr: got %b expected 0", intr); end
    cyc(1);
    n_checks++;
    if (intr !== 1'b1) begin n_fail++; $display("FAIL out1_ack_b3 intr: got %b expected 1", intr); end
    write_port = 1'b1;
    cyc(1);
    n_checks++;
    if (intr !== 1'b0) begin n_fail++; $display("FAIL out1_next_wr intr: got %b expected 0", intr); end
    write_port = 1'b0;
    cyc(2);
  endtask

  task automatic test_mode2();
    set_mode(CONTROL_MODE_2, PORT_INPUT);
    set_inte(INTE_SEL_IN, 1'b1);
    set_inte(INTE_SEL_OUT, 1'b1);
    write_port = 1'b1;
    cyc(1);
    write_port = 1'b0;
    cyc(1);
    n_checks++;
    if ({obf_n, intr, hiz} !== 3'b001) begin n_fail++; $display("FAIL m2_after_wr obf_n,intr,hiz: got %b expected 001", {obf_n, intr, hiz}); end
    ack_n = 1'b0;
    stb_n = 1'b0;                                   // A
    cyc(2);
    n_checks++;
    if ({hiz, strobe} !== 2'b01) begin n_fail++; $display("FAIL m2_a2 hiz,strobe: got %b expected 01", {hiz, strobe}); end
    cyc(1);                                         // A+3
    n_checks++;
    if ({ibf, obf_n, hiz} !== 3'b110) begin n_fail++; $display("FAIL m2_a3 ibf,obf_n,hiz: got %b expected 110", {ibf, obf_n, hiz}); end
    n_checks++;
    if ({b_strobe, b_hiz, b_ibf, b_obf_n, b_intr} !== 5'b01010) begin n_fail++; $display("FAIL m2_disabled_outputs: got %b expected 01010", {b_strobe, b_hiz, b_ibf, b_obf_n, b_intr}); end
    stb_n = 1'b1;
    cyc(3);                                         // A+6
    n_checks++;
    if ({intr, obf_n, hiz} !== 3'b110) begin n_fail++; $display("FAIL m2_in_req intr,obf_n,hiz: got %b expected 110", {intr, obf_n, hiz}); end
    write_inte = 1'b1;
    inte_sel   = INTE_SEL_IN;
    inte_value = 1'b0;
    ack_n      = 1'b1;
    cyc(1);
    write_inte = 1'b0;
    cyc(1);                                         // A+8
    n_checks++;
    if ({intr, hiz, inte_in} !== 3'b010) begin n_fail++; $display("FAIL m2_inte_clear intr,hiz,inte_in: got %b expected 010", {intr, hiz, inte_in}); end
    cyc(1);                                         // A+9
    n_checks++;
    if ({intr, ibf} !== 2'b11) begin n_fail++; $display("FAIL m2_out_req intr,ibf: got %b expected 11", {intr, ibf}); end
    n_checks++;
    if ({b_strobe, b_hiz, b_ibf, b_obf_n, b_intr} !== 5'b01010) begin n_fail++; $display("FAIL m2_disabled_outputs_late: got %b expected 01010", {b_strobe, b_hiz, b_ibf, b_obf_n, b_intr}); end
  endtask

  task automatic test_simultaneous();
    set_mode(CONTROL_MODE_1, PORT_OUTPUT);
    ack_n = 1'b0;
    cyc(1);
    write_port = 1'b1;
    cyc(1);
    write_port = 1'b0;                              // wr_end meets the ack fall
    cyc(1);
    n_checks++;
    if (obf_n !== 1'b0) begin n_fail++; $display("FAIL sim_wr_end_vs_ack obf_n: got %b expected 0", obf_n); end
    ack_n = 1'b1;
    cyc(3);
    set_mode(CONTROL_MODE_1, PORT_INPUT);
    stb_n = 1'b0;
    cyc(1);
    read_port = 1'b1;
    cyc(1);
    read_port = 1'b0;                               // rd_end meets the stb fall
    cyc(1);
    n_checks++;
    if (ibf !== 1'b1) begin n_fail++; $display("FAIL sim_stb_vs_rd_end ibf: got %b expected 1", ibf); end
    stb_n = 1'b1;
    cyc(3);
  endtask

  task automatic test_update_mode();
    set_mode(CONTROL_MODE_1, PORT_INPUT);
    set_inte(INTE_SEL_IN, 1'b1);
    stb_n = 1'b0;
    cyc(3);
    stb_n = 1'b1;
    cyc(3);
    n_checks++;
    if ({ibf, intr} !== 2'b11) begin n_fail++; $display("FAIL upd_pending ibf,intr: got %b expected 11", {ibf, intr}); end
    update_mode = 1'b1;
    write_inte  = 1'b1;
    inte_sel    = INTE_SEL_OUT;
    inte_value  = 1'b1;
    cyc(1);
    update_mode = 1'b0;
    write_inte  = 1'b0;
    n_checks++;
    if ({ibf, obf_n, intr, inte_in, inte_out} !== 5'b01000) begin n_fail++; $display("FAIL upd_cleared ibf,obf_n,intr,inte_in,inte_out: got %b expected 01000", {ibf, obf_n, intr, inte_in, inte_out}); end
  endtask

  task automatic test_reset_stb_low();
    set_mode(CONTROL_MODE_1, PORT_INPUT);
    stb_n = 1'b0;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    n_checks++;
    if ({ibf, obf_n, intr} !== 3'b010) begin n_fail++; $display("FAIL rst_stb_low_now ibf,obf_n,intr: got %b expected 010", {ibf, obf_n, intr}); end
    cyc(5);
    n_checks++;
    if (ibf !== 1'b0) begin n_fail++; $display("FAIL rst_stb_held ibf: got %b expected 0", ibf); end
    stb_n = 1'b1;                                   // T
    cyc(3);
    stb_n = 1'b0;
    cyc(2);                                         // T+5
    n_checks++;
    if (ibf !== 1'b0) begin n_fail++; $display("FAIL rst_stb_t5 ibf: got %b expected 0", ibf); end
    cyc(1);
    n_checks++;
    if (ibf !== 1'b1) begin n_fail++; $display("FAIL rst_stb_new_edge ibf: got %b expected 1", ibf); end
    stb_n = 1'b1;
    cyc(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    mode_select_reg = CONTROL_MODE_0;
    port_io_reg     = PORT_OUTPUT;
    update_mode     = 1'b0;
    read_port       = 1'b0;
    write_port      = 1'b0;
    write_inte      = 1'b0;
    inte_sel        = INTE_SEL_IN;
    inte_value      = 1'b0;
    stb_n           = 1'b1;
    ack_n           = 1'b1;
    test_reset();
    test_mode1_input();
    test_mode1_output();
    test_mode2();
    test_simultaneous();
    test_update_mode();
    test_reset_stb_low();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
